// File: rtl/mem_access_stage.sv
// Memory stage between execute and writeback: issues aligned loads/stores
// on a req/ack bus with lane steering, extension, misalign and timeout faults.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   ex_in_*              instruction from execute (valid, mem_en, mem_op,
//                        alu_output/address, store_value, rd_en, rd_key)
//   ex_out_ready         high while idle; execute stalls otherwise
//   mem_out_*            retired instruction to writeback (valid pulse,
//                        rd_value, rd_en, rd_key, misaligned, bus_error)
//   bus_req/we/addr/be/wdata   data bus request, held until ack or timeout
//   bus_ack/rdata        bus completion and read data (same cycle)
module mem_access_stage #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int KEY_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_in_valid,
    output logic                ex_out_ready,
    input  logic                ex_in_mem_en,
    input  logic [3:0]          ex_in_mem_op,
    input  logic [XLEN-1:0]     ex_in_alu_output,
    input  logic [XLEN-1:0]     ex_in_store_value,
    input  logic                ex_in_rd_en,
    input  logic [KEY_W-1:0]    ex_in_rd_key,
    output logic                mem_out_valid,
    output logic [XLEN-1:0]     mem_out_rd_value,
    output logic                mem_out_rd_en,
    output logic [KEY_W-1:0]    mem_out_rd_key,
    output logic                mem_out_misaligned,
    output logic                mem_out_bus_error,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BE_W - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_d;

    // captured request context for the access in flight
    logic [3:0]       op_q, op_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             rd_en_q, rd_en_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    // next values of the registered outputs
    logic              valid_d, out_rd_en_d, mis_d, berr_d;
    logic [XLEN-1:0]   rd_value_d;
    logic [KEY_W-1:0]  out_key_d;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BE_W-1:0]   be_d;
    logic [XLEN-1:0]   wdata_d;

    logic              accept;
    logic              mis;
    logic              timeout_hit;
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   size_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_value;

    assign accept = ex_in_valid && (state == IDLE);
    assign off    = ex_in_alu_output[OFF_W-1:0];
    assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // alignment check and byte-enable footprint per access size
    always_comb begin
        mis       = 1'b0;
        size_mask = '0;
        unique case (ex_in_mem_op[1:0])
            2'd0: begin
                mis       = 1'b0;
                size_mask = BE_W'(1);
            end
            2'd1: begin
                mis       = ex_in_alu_output[0];
                size_mask = BE_W'(3);
            end
            2'd2: begin
                mis       = |ex_in_alu_output[1:0];
                size_mask = BE_W'(15);
            end
            2'd3: begin
                mis       = (XLEN == 32) || (|ex_in_alu_output[2:0]);
                size_mask = '1;
            end
        endcase
    end

    // read lane steering plus sign/zero extension
    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_value = shifted;
        unique case (op_q[1:0])
            2'd0: load_value = op_q[2] ? XLEN'(shifted[7:0])
                                       : XLEN'($signed(shifted[7:0]));
            2'd1: load_value = op_q[2] ? XLEN'(shifted[15:0])
                                       : XLEN'($signed(shifted[15:0]));
            2'd2: load_value = op_q[2] ? XLEN'(shifted[31:0])
                                       : XLEN'($signed(shifted[31:0]));
            2'd3: load_value = shifted;
        endcase
    end

    // next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept && ex_in_mem_en && !mis)
                    state_d = ACCESS;
            end
            ACCESS: begin
                if (bus_ack || timeout_hit)
                    state_d = IDLE;
            end
        endcase
    end

    // output / datapath next values
    always_comb begin
        valid_d     = 1'b0;
        out_rd_en_d = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;
        rd_value_d  = mem_out_rd_value;
        out_key_d   = mem_out_rd_key;
        req_d       = 1'b0;
        we_d        = bus_we;
        addr_d      = bus_addr;
        be_d        = bus_be;
        wdata_d     = bus_wdata;
        op_d        = op_q;
        off_d       = off_q;
        rd_en_d     = rd_en_q;
        key_d       = key_q;
        cnt_d       = cnt;
        unique case (state)
            IDLE: begin
                if (accept && !ex_in_mem_en) begin
                    valid_d     = 1'b1;
                    rd_value_d  = ex_in_alu_output;
                    out_rd_en_d = ex_in_rd_en;
                    out_key_d   = ex_in_rd_key;
                end else if (accept && mis) begin
                    valid_d   = 1'b1;
                    mis_d     = 1'b1;
                    out_key_d = ex_in_rd_key;
                end else if (accept) begin
                    req_d   = 1'b1;
                    we_d    = ex_in_mem_op[3];
                    addr_d  = ADDR_W'(ex_in_alu_output) & ~LANE_MASK;
                    be_d    = size_mask << off;
                    wdata_d = ex_in_store_value << {off, 3'b000};
                    op_d    = ex_in_mem_op;
                    off_d   = off;
                    rd_en_d = ex_in_rd_en;
                    key_d   = ex_in_rd_key;
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    valid_d   = 1'b1;
                    out_key_d = key_q;
                    if (!op_q[3]) begin
                        out_rd_en_d = rd_en_q;
                        rd_value_d  = load_value;
                    end
                end else if (timeout_hit) begin
                    valid_d   = 1'b1;
                    berr_d    = 1'b1;
                    out_key_d = key_q;
                end else begin
                    req_d = 1'b1;
                    cnt_d = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            ex_out_ready       <= 1'b1;
            mem_out_valid      <= 1'b0;
            mem_out_rd_value   <= '0;
            mem_out_rd_en      <= 1'b0;
            mem_out_rd_key     <= '0;
            mem_out_misaligned <= 1'b0;
            mem_out_bus_error  <= 1'b0;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_be             <= '0;
            bus_wdata          <= '0;
            op_q               <= '0;
            off_q              <= '0;
            rd_en_q            <= 1'b0;
            key_q              <= '0;
            cnt                <= '0;
        end else begin
            state              <= state_d;
            ex_out_ready       <= (state_d == IDLE);
            mem_out_valid      <= valid_d;
            mem_out_rd_value   <= rd_value_d;
            mem_out_rd_en      <= out_rd_en_d;
            mem_out_rd_key     <= out_key_d;
            mem_out_misaligned <= mis_d;
            mem_out_bus_error  <= berr_d;
            bus_req            <= req_d;
            bus_we             <= we_d;
            bus_addr           <= addr_d;
            bus_be             <= be_d;
            bus_wdata          <= wdata_d;
            op_q               <= op_d;
            off_q              <= off_d;
            rd_en_q            <= rd_en_d;
            key_q              <= key_d;
            cnt                <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: random instruction stream against a byte-level
// memory model, with a scoreboard-driven monitor and a wait-state bus slave.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_in_valid;
    logic        ex_out_ready;
    logic        ex_in_mem_en;
    logic [3:0]  ex_in_mem_op;
    logic [31:0] ex_in_alu_output;
    logic [31:0] ex_in_store_value;
    logic        ex_in_rd_en;
    logic [4:0]  ex_in_rd_key;
    logic        mem_out_valid;
    logic [31:0] mem_out_rd_value;
    logic        mem_out_rd_en;
    logic [4:0]  mem_out_rd_key;
    logic        mem_out_misaligned;
    logic        mem_out_bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_access_stage #(
        .XLEN(32), .ADDR_W(32), .KEY_W(5), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_in_valid(ex_in_valid), .ex_out_ready(ex_out_ready),
        .ex_in_mem_en(ex_in_mem_en), .ex_in_mem_op(ex_in_mem_op),
        .ex_in_alu_output(ex_in_alu_output),
        .ex_in_store_value(ex_in_store_value),
        .ex_in_rd_en(ex_in_rd_en), .ex_in_rd_key(ex_in_rd_key),
        .mem_out_valid(mem_out_valid), .mem_out_rd_value(mem_out_rd_value),
        .mem_out_rd_en(mem_out_rd_en), .mem_out_rd_key(mem_out_rd_key),
        .mem_out_misaligned(mem_out_misaligned),
        .mem_out_bus_error(mem_out_bus_error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] val;
        bit          chk_val;
        logic        rd_en;
        logic [4:0]  key;
        logic        mis;
        logic        berr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          waits;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    // reference memory (bytes) and the slave's storage (words), same contents
    logic [7:0]  mem_b [0:255];
    logic [31:0] mem_w [0:63];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    task automatic check_rst();
        chk("rst_ready", ex_out_ready, 1);
        chk("rst_valid", mem_out_valid, 0);
        chk("rst_rd_value", mem_out_rd_value, 0);
        chk("rst_rd_en", mem_out_rd_en, 0);
        chk("rst_rd_key", mem_out_rd_key, 0);
        chk("rst_misaligned", mem_out_misaligned, 0);
        chk("rst_bus_error", mem_out_bus_error, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
    endtask

    // Present one instruction (called just after a rising edge), wait until
    // it is accepted, and record what the bus and writeback should see.
    task automatic issue(input bit m, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] sv,
                         input bit re, input logic [4:0] k,
                         input int w, input bit track);
        exp_t e;
        bus_t b;
        int n, guard;
        bit mis, tmo;
        logic [63:0] v;
        ex_in_valid = 1'b1;
        ex_in_mem_en = m;
        ex_in_mem_op = op;
        ex_in_alu_output = a;
        ex_in_store_value = sv;
        ex_in_rd_en = re;
        ex_in_rd_key = k;
        guard = 0;
        @(negedge clk);
        while (!ex_out_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) begin
            chk("accept_wait", 1, 0);
        end else begin
            n = 1 << op[1:0];
            mis = m && (op[1:0] == 2'd3 || (a & (n - 1)) != 0);
            tmo = m && !mis && (w >= TO);
            e.val = 0;
            e.chk_val = 0;
            e.rd_en = 0;
            e.key = k;
            e.mis = mis;
            e.berr = tmo;
            // cyc + 1 is the cycle count right after the accepting edge
            e.cyc = cyc + 1;
            if (!m) begin
                e.val = a;
                e.chk_val = 1;
                e.rd_en = re;
            end else if (!mis) begin
                b.addr = a & ~32'd3;
                b.be = 4'(((1 << n) - 1) << (a & 3));
                b.we = op[3];
                b.wdata = sv << (8 * (a & 3));
                b.waits = w;
                bus_q.push_back(b);
                if (tmo) begin
                    e.cyc = cyc + 1 + TO;
                end else begin
                    e.cyc = cyc + 2 + w;
                    if (op[3]) begin
                        for (int i = 0; i < n; i++)
                            mem_b[(a + i) & 255] = 8'(sv >> (8 * i));
                    end else begin
                        v = 0;
                        for (int i = 0; i < n; i++)
                            v = v | (64'(mem_b[(a + i) & 255]) << (8 * i));
                        if (!op[2] && v[8 * n - 1])
                            v = v | (~64'd0 << (8 * n));
                        e.val = v[31:0];
                        e.chk_val = 1;
                        e.rd_en = re;
                    end
                end
            end
            if (track) exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ex_in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus_req) && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        chk("drain_scoreboard", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // bus slave: wait states per request, late/stray acks while idle
    initial begin
        bit active;
        int cnt;
        bus_t cur;
        logic [5:0] idx;
        active = 0;
        cnt = 0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            bus_rdata = $urandom();
            if (bus_req) begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_req", 1, 0);
                        cur = '{default: '0};
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_be", bus_be, cur.be);
                chk("bus_we", bus_we, cur.we);
                if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                if (cnt == cur.waits) begin
                    bus_ack = 1'b1;
                    idx = bus_addr[7:2];
                    bus_rdata = mem_w[idx];
                    if (bus_we)
                        for (int bb = 0; bb < 4; bb++)
                            if (bus_be[bb])
                                mem_w[idx][8*bb +: 8] = bus_wdata[8*bb +: 8];
                    active = 0;
                end
                cnt++;
            end else begin
                if (active && !reset) chk("timeout_req_cycles", cnt, TO);
                if (active || $urandom_range(0, 7) == 0) bus_ack = 1'b1;
                active = 0;
            end
        end
    end

    // monitor: compare every retired instruction against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("rd_en", mem_out_rd_en, e.rd_en);
                    chk("rd_key", mem_out_rd_key, e.key);
                    chk("misaligned", mem_out_misaligned, e.mis);
                    chk("bus_error", mem_out_bus_error, e.berr);
                    if (e.chk_val) chk("rd_value", mem_out_rd_value, e.val);
                end
            end else begin
                chk("flags_when_idle",
                    {mem_out_misaligned, mem_out_bus_error}, 0);
            end
        end
    end

    initial begin
        logic [31:0] w, a;
        logic [3:0] op;
        int r, wt;
        bit m;
        reset = 1'b1;
        ex_in_valid = 1'b0;
        ex_in_mem_en = 1'b0;
        ex_in_mem_op = '0;
        ex_in_alu_output = '0;
        ex_in_store_value = '0;
        ex_in_rd_en = 1'b0;
        ex_in_rd_key = '0;
        for (int i = 0; i < 64; i++) begin
            w = (i == 0) ? 32'h80FF_FFFF : $urandom();
            mem_w[i] = w;
            for (int j = 0; j < 4; j++) mem_b[4*i + j] = w[8*j +: 8];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst();
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(0, 4'h0, 32'h1234, 0, 1, 5'd5, 0, 1);
        issue(0, 4'h0, 32'hDEAD_BEEF, 0, 0, 5'd7, 0, 1);
        issue(0, 4'h8, 32'h0000_0042, 0, 1, 5'd31, 0, 1);
        issue(1, 4'b0000, 32'h1003, 0, 1, 5'd3, 2, 1);
        issue(1, 4'b0100, 32'h1003, 0, 1, 5'd4, 2, 1);
        issue(1, 4'b1001, 32'h2002, 32'hABCD_1234, 1, 5'd6, 0, 1);
        issue(1, 4'b0001, 32'h0002, 0, 1, 5'd8, 1, 1);
        issue(1, 4'b0010, 32'h3001, 0, 1, 5'd9, 0, 1);
        issue(1, 4'b0011, 32'h3000, 0, 1, 5'd12, 0, 1);
        issue(1, 4'b0010, 32'h3000, 0, 1, 5'd10, 100, 1);
        issue(1, 4'b0010, 32'h3004, 0, 1, 5'd13, TO - 1, 1);
        issue(1, 4'b1010, 32'h3008, 32'h5A5A_A5A5, 1, 5'd14, TO, 1);
        issue(1, 4'b0110, 32'h3008, 0, 1, 5'd15, 0, 1);

        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            m = ($urandom_range(0, 3) != 0);
            op = 4'($urandom());
            a = $urandom();
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << op[1:0]) - 32'd1);
            r = $urandom_range(0, 9);
            wt = (r < 7) ? r % 4 : (r == 7) ? TO - 1 : (r == 8) ? TO : 50;
            issue(m, op, a, $urandom(), 1'($urandom()),
                  5'($urandom()), wt, 1);
        end
        drain();

        // reset while a load is waiting on the bus: nothing may retire
        issue(1, 4'b0010, 32'h0000_0040, 0, 1, 5'd11, 100, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_rst();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 4'h0, 32'h0BAD_F00D, 0, 1, 5'd21, 0, 1);
        drain();
        chk("bus_queue_empty", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
